// File: rtl/driver_display_7seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment codes
// (active-low, {g,f,e,d,c,b,a}) and the default digit count.
package driver_display_7seg_pkg;

    localparam int BUS_DAT       = 12;
    localparam int N_DIGITOS_DEF = (BUS_DAT + 4) / 4;

    localparam logic [6:0] SEG_0       = 7'b1000000;
    localparam logic [6:0] SEG_1       = 7'b1111001;
    localparam logic [6:0] SEG_2       = 7'b0100100;
    localparam logic [6:0] SEG_3       = 7'b0110000;
    localparam logic [6:0] SEG_4       = 7'b0011001;
    localparam logic [6:0] SEG_5       = 7'b0010010;
    localparam logic [6:0] SEG_6       = 7'b0000010;
    localparam logic [6:0] SEG_7       = 7'b1111000;
    localparam logic [6:0] SEG_8       = 7'b0000000;
    localparam logic [6:0] SEG_9       = 7'b0010000;
    localparam logic [6:0] SEG_GUION   = 7'b0111111;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

endpackage

// File: rtl/driver_display_7seg_decodificador.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module decodificador_bcd_7seg
    import driver_display_7seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segmentos
);

    // Digit lookup; anything above 9 is flagged as invalid with a dash
    always_comb begin
        segmentos = SEG_GUION;
        case (bcd)
            4'd0:    segmentos = SEG_0;
            4'd1:    segmentos = SEG_1;
            4'd2:    segmentos = SEG_2;
            4'd3:    segmentos = SEG_3;
            4'd4:    segmentos = SEG_4;
            4'd5:    segmentos = SEG_5;
            4'd6:    segmentos = SEG_6;
            4'd7:    segmentos = SEG_7;
            4'd8:    segmentos = SEG_8;
            4'd9:    segmentos = SEG_9;
            default: segmentos = SEG_GUION;
        endcase
    end

endmodule

// File: rtl/driver_display_7seg.sv
// Time-multiplexed common-anode 7-segment driver with tear-free frame updates
// and leading-zero blanking.
module driver_display_7seg
    import driver_display_7seg_pkg::*;
#(
    parameter int N_DIGITOS    = N_DIGITOS_DEF,
    parameter int DIV_REFRESCO = 50000,
    parameter int BLANQUEO     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*N_DIGITOS-1:0] reg_BCD,
    input  logic                   cargar,
    output logic [N_DIGITOS-1:0]   anodos,
    output logic [6:0]             segmentos,
    output logic                   punto
);

    localparam int PW = (DIV_REFRESCO > 2) ? $clog2(DIV_REFRESCO) : 1;
    localparam int DW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [PW-1:0]          PRESC_MAX = PW'(DIV_REFRESCO - 1);
    localparam logic [DW-1:0]          DIG_MAX   = DW'(N_DIGITOS - 1);
    localparam logic [N_DIGITOS-1:0]   AN_UNO    = N_DIGITOS'(1);
    localparam logic                   BLANK_EN  = (BLANQUEO != 0);

    logic [PW-1:0]          prescaler_r;
    logic [DW-1:0]          digito_r;
    logic [4*N_DIGITOS-1:0] shadow_r;
    logic [4*N_DIGITOS-1:0] activo_r;
    logic [N_DIGITOS-1:0]   anodos_r;
    logic [6:0]             segmentos_r;
    logic                   punto_r;

    logic                   tick_s;
    logic                   wrap_s;
    logic [N_DIGITOS-1:0]   blanco_s;
    logic                   ceros_s;
    logic [3:0]             digito_sel_s;
    logic [6:0]             seg_dec_s;
    logic                   apagar_s;

    assign tick_s = (prescaler_r == PRESC_MAX);
    assign wrap_s = tick_s && (digito_r == DIG_MAX);

    // Refresh prescaler and scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r <= '0;
            digito_r    <= '0;
        end else begin
            if (tick_s) begin
                prescaler_r <= '0;
                if (digito_r == DIG_MAX) begin
                    digito_r <= '0;
                end else begin
                    digito_r <= digito_r + DW'(1);
                end
            end else begin
                prescaler_r <= prescaler_r + PW'(1);
            end
        end
    end

    // Shadow captures every load; activo only follows it at the frame boundary,
    // and a load on the boundary edge itself goes straight through.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r <= '0;
            activo_r <= '0;
        end else begin
            if (cargar) begin
                shadow_r <= reg_BCD;
            end
            if (wrap_s) begin
                activo_r <= cargar ? reg_BCD : shadow_r;
            end
        end
    end

    // Digit k>0 is dark when it and every more significant digit are zero
    always_comb begin
        blanco_s = '0;
        ceros_s  = 1'b1;
        for (int k = N_DIGITOS - 1; k >= 1; k--) begin
            ceros_s     = ceros_s & (activo_r[4*k +: 4] == 4'h0);
            blanco_s[k] = ceros_s;
        end
    end

    assign digito_sel_s = activo_r[{digito_r, 2'b00} +: 4];
    assign apagar_s     = BLANK_EN && blanco_s[digito_r];

    decodificador_bcd_7seg u_decodificador (
        .bcd       (digito_sel_s),
        .segmentos (seg_dec_s)
    );

    // Registered anode/segment drive, one clock behind the scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            anodos_r    <= {N_DIGITOS{1'b1}};
            segmentos_r <= SEG_APAGADO;
            punto_r     <= 1'b1;
        end else if (apagar_s) begin
            anodos_r    <= {N_DIGITOS{1'b1}};
            segmentos_r <= SEG_APAGADO;
            punto_r     <= 1'b1;
        end else begin
            anodos_r    <= ~(AN_UNO << digito_r);
            segmentos_r <= seg_dec_s;
            punto_r     <= 1'b1;
        end
    end

    assign anodos    = anodos_r;
    assign segmentos = segmentos_r;
    assign punto     = punto_r;

endmodule
